// File: rtl/mon_cdc_pkg.sv
// Shared types and constants for the monitor CDC write-side launcher.
package mon_cdc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } mon_cdc_state_t;

  localparam int MON_CDC_DSIZE = 34;

  // Width of the handshake timeout counter; a disabled timeout still needs one bit.
  function automatic int cntWidth(input int t);
    if (t > 0) begin
      return $clog2(t + 1);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/mon_cdc_fifo.sv
// Single-clock synchronous FIFO holding monitor words until the launcher issues them.
// The head word is read straight from the storage registers at the read pointer.
module mon_cdc_fifo
  import mon_cdc_pkg::*;
#(
  parameter int DSIZE = MON_CDC_DSIZE,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstB,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DSIZE-1:0]       wrData,
  output logic [DSIZE-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [DSIZE-1:0] memR [DEPTH];
  logic [AW-1:0]    wrPtrR;
  logic [AW-1:0]    rdPtrR;
  logic [AW:0]      countR;
  logic             pushS;
  logic             popS;

  assign full  = (countR == (AW + 1)'(DEPTH));
  assign empty = (countR == (AW + 1)'(0));
  assign level = countR;
  assign head  = memR[rdPtrR];
  assign pushS = push && !full;
  assign popS  = pop && !empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rstB) begin
      wrPtrR <= '0;
      rdPtrR <= '0;
      countR <= '0;
    end else begin
      if (pushS) begin
        wrPtrR <= wrPtrR + AW'(1);
      end
      if (popS) begin
        rdPtrR <= rdPtrR + AW'(1);
      end
      case ({pushS, popS})
        2'b10:   countR <= countR + (AW + 1)'(1);
        2'b01:   countR <= countR - (AW + 1)'(1);
        default: countR <= countR;
      endcase
    end
  end

  // Word storage, cleared on reset so no stale word survives an abandon.
  always_ff @(posedge clk) begin
    if (!rstB) begin
      for (int i = 0; i < DEPTH; i++) begin
        memR[i] <= '0;
      end
    end else if (pushS) begin
      memR[wrPtrR] <= wrData;
    end
  end

endmodule

// File: rtl/mon_cdc_launcher.sv
// Write-side driver for the monitor CDC recirculation synchronizer: queues monitor words,
// launches them one at a time and waits for the copy acknowledge before the next launch.
module mon_cdc_launcher
  import mon_cdc_pkg::*;
#(
  parameter int DSIZE   = MON_CDC_DSIZE,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                   WrClk,
  input  logic                   WrRstB,
  input  logic [DSIZE-1:0]       MonData,
  input  logic                   MonValid,
  output logic                   MonReady,
  output logic                   Write,
  output logic [DSIZE-1:0]       InData,
  input  logic                   WriteDone,
  output logic                   Busy,
  output logic [$clog2(DEPTH):0] Level,
  input  logic                   ErrClr,
  output logic                   Overflow,
  output logic                   Timeout
);

  localparam int CW = cntWidth(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  mon_cdc_state_t   stateR;
  mon_cdc_state_t   stateS;
  logic [CW-1:0]    cntR;
  logic [CW-1:0]    cntS;
  logic             launchS;
  logic             toHitS;
  logic             dropS;
  logic             writeR;
  logic [DSIZE-1:0] inDataR;
  logic             busyR;
  logic             wdDlyR;
  logic             overflowR;
  logic             timeoutR;
  logic [DSIZE-1:0] fifoHead;
  logic             fifoFull;
  logic             fifoEmpty;

  // MonReady follows the registered occupancy only; a same-cycle pop does not free a slot.
  assign MonReady = !fifoFull;
  assign dropS    = MonValid && fifoFull;
  assign Write    = writeR;
  assign InData   = inDataR;
  assign Busy     = busyR;
  assign Overflow = overflowR;
  assign Timeout  = timeoutR;

  mon_cdc_fifo #(
    .DSIZE(DSIZE),
    .DEPTH(DEPTH)
  ) uFifo (
    .clk   (WrClk),
    .rstB  (WrRstB),
    .push  (MonValid),
    .pop   (launchS),
    .wrData(MonData),
    .head  (fifoHead),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .level (Level)
  );

  // Next-state logic: launch from IDLE, wait for an acknowledge edge or timeout, then
  // hold in RELEASE until the synchronizer drops WriteDone.
  always_comb begin
    stateS  = stateR;
    cntS    = cntR;
    launchS = 1'b0;
    toHitS  = 1'b0;
    case (stateR)
      IDLE: begin
        if (!fifoEmpty) begin
          launchS = 1'b1;
          cntS    = '0;
          stateS  = WAIT;
        end else begin
          stateS  = IDLE;
        end
      end
      WAIT: begin
        if (WriteDone && !wdDlyR) begin
          stateS = RELEASE;
        end else begin
          if (cntR != CNT_MAX) begin
            cntS = cntR + CW'(1);
          end else begin
            cntS = cntR;
          end
          if ((TIMEOUT != 0) && (cntR == CNT_LAST)) begin
            toHitS = 1'b1;
            stateS = RELEASE;
          end else begin
            stateS = WAIT;
          end
        end
      end
      RELEASE: begin
        if (WriteDone) begin
          stateS = RELEASE;
        end else begin
          stateS = IDLE;
        end
      end
      default: begin
        stateS = IDLE;
      end
    endcase
  end

  // State, counter, launch outputs, acknowledge history and sticky error flags.
  always_ff @(posedge WrClk) begin
    if (!WrRstB) begin
      stateR    <= IDLE;
      cntR      <= '0;
      writeR    <= 1'b0;
      inDataR   <= '0;
      busyR     <= 1'b0;
      wdDlyR    <= 1'b0;
      overflowR <= 1'b0;
      timeoutR  <= 1'b0;
    end else begin
      stateR    <= stateS;
      cntR      <= cntS;
      writeR    <= launchS;
      if (launchS) begin
        inDataR <= fifoHead;
      end
      busyR     <= (stateS != IDLE);
      wdDlyR    <= WriteDone;
      overflowR <= dropS  | (overflowR & !ErrClr);
      timeoutR  <= toHitS | (timeoutR & !ErrClr);
    end
  end

endmodule

// File: tb/tb_mon_cdc_launcher.sv
// Bench for mon_cdc_launcher: directed handshake scenarios on a TIMEOUT=16 instance and a
// randomized run against a queue-based synchronizer model on a TIMEOUT=64 instance.
module tb_mon_cdc_launcher;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstB;
  logic        mvA, wdA, ecA, rdyA, wrA, busyA, ovA, toA;
  logic [33:0] mdA, inA;
  logic [2:0]  lvlA;
  logic        mvB, wdB, ecB, rdyB, wrB, busyB, ovB, toB;
  logic [33:0] mdB, inB;
  logic [2:0]  lvlB;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mon_cdc_launcher #(.DSIZE(34), .DEPTH(DEPTH), .TIMEOUT(16)) uDutA (
    .WrClk(clk), .WrRstB(rstB), .MonData(mdA), .MonValid(mvA), .MonReady(rdyA),
    .Write(wrA), .InData(inA), .WriteDone(wdA), .Busy(busyA), .Level(lvlA),
    .ErrClr(ecA), .Overflow(ovA), .Timeout(toA)
  );

  mon_cdc_launcher #(.DSIZE(34), .DEPTH(DEPTH), .TIMEOUT(64)) uDutB (
    .WrClk(clk), .WrRstB(rstB), .MonData(mdB), .MonValid(mvB), .MonReady(rdyB),
    .Write(wrB), .InData(inB), .WriteDone(wdB), .Busy(busyB), .Level(lvlB),
    .ErrClr(ecB), .Overflow(ovB), .Timeout(toB)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkIdleA(input string tag);
    chk({tag, "_level"},    64'(lvlA),  64'(0));
    chk({tag, "_write"},    64'(wrA),   64'(0));
    chk({tag, "_indata"},   64'(inA),   64'(0));
    chk({tag, "_busy"},     64'(busyA), 64'(0));
    chk({tag, "_overflow"}, 64'(ovA),   64'(0));
    chk({tag, "_timeout"},  64'(toA),   64'(0));
    chk({tag, "_ready"},    64'(rdyA),  64'(1));
  endtask

  logic [33:0] burst [4];
  logic [33:0] acc [$];
  logic [33:0] expW, mdD;
  logic        wdDrv, mvD, ovExp, done;
  int          nw, wdT, pre, nAcc, nRx, wdWait, wdLen;

  initial begin
    rstB = 1'b0;
    mvA = 1'b0; mdA = '0; wdA = 1'b0; ecA = 1'b0;
    mvB = 1'b0; mdB = '0; wdB = 1'b0; ecB = 1'b0;
    burst[0] = 34'h1_1111_0001; burst[1] = 34'h2_2222_0002;
    burst[2] = 34'h3_3333_0003; burst[3] = 34'h0_4444_0004;

    // Reset state
    tick(); tick();
    chkIdleA("reset");
    chk("reset_b_ready", 64'(rdyB), 64'(1));
    rstB = 1'b1;
    tick();

    // 1: single word, acknowledge 6 cycles after Write
    mvA = 1'b1; mdA = 34'h2_DEAD_BEEF;
    tick();
    mvA = 1'b0;
    chk("single_level_queued", 64'(lvlA), 64'(1));
    chk("single_no_write_yet", 64'(wrA), 64'(0));
    tick();
    chk("single_write",  64'(wrA),   64'(1));
    chk("single_indata", 64'(inA),   64'(34'h2_DEAD_BEEF));
    chk("single_level0", 64'(lvlA),  64'(0));
    chk("single_busy",   64'(busyA), 64'(1));
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("single_write_once", 64'(wrA),   64'(0));
      chk("single_busy_wait",  64'(busyA), 64'(1));
      chk("single_hold",       64'(inA),   64'(34'h2_DEAD_BEEF));
    end
    wdA = 1'b1;
    tick();
    chk("single_busy_release", 64'(busyA), 64'(1));
    chk("single_hold_release", 64'(inA),   64'(34'h2_DEAD_BEEF));
    wdA = 1'b0;
    tick();
    chk("single_idle",     64'(busyA), 64'(0));
    chk("single_hold_end", 64'(inA),   64'(34'h2_DEAD_BEEF));

    // 2: burst of 4, WriteDone high 3 cycles per word
    mvA = 1'b1; mdA = burst[0]; nw = 0; wdT = 0; done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      wdDrv = wdA;
      tick();
      if (wrA) begin
        chk("burst_wd_low_at_launch", 64'(wdDrv), 64'(0));
        if (nw < 4) chk("burst_order", 64'(inA), 64'(burst[nw]));
        nw++;
        wdT = 6;
      end
      if (c < 3) begin
        mvA = 1'b1; mdA = burst[c + 1];
      end else begin
        mvA = 1'b0;
      end
      if (wdT > 0) wdT--;
      wdA = (wdT >= 1 && wdT <= 3);
      if (nw == 4 && wdT == 0 && !busyA && c > 4) done = 1'b1;
    end
    chk("burst_finished", 64'(done), 64'(1));
    chk("burst_count",    64'(nw),   64'(4));
    chk("burst_overflow", 64'(ovA),  64'(0));

    // 3: overflow with WriteDone held low
    for (int i = 0; i < 6; i++) begin
      mvA = 1'b1; mdA = 34'(i + 16);
      tick();
      if (i == 4) begin
        chk("ovf_full_level", 64'(lvlA), 64'(4));
        chk("ovf_full_ready", 64'(rdyA), 64'(0));
        chk("ovf_not_yet",    64'(ovA),  64'(0));
      end
    end
    mvA = 1'b0;
    chk("ovf_set",   64'(ovA),  64'(1));
    chk("ovf_level", 64'(lvlA), 64'(4));
    chk("ovf_ready", 64'(rdyA), 64'(0));
    chk("ovf_inflight", 64'(inA), 64'(16));
    mvA = 1'b1; ecA = 1'b1;
    tick();
    chk("ovf_set_wins", 64'(ovA), 64'(1));
    mvA = 1'b0;
    tick();
    chk("ovf_cleared", 64'(ovA), 64'(0));
    ecA = 1'b0; mvA = 1'b1;
    tick();
    mvA = 1'b0;
    chk("ovf_set_again", 64'(ovA), 64'(1));
    rstB = 1'b0;
    tick();
    chkIdleA("rst_full");
    rstB = 1'b1;

    // 4: timeout after 16 cycles, next word launches, late WriteDone ignored
    mvA = 1'b1; mdA = 34'h0_1234_5678;
    tick();
    mvA = 1'b0;
    tick();
    chk("to_write",  64'(wrA), 64'(1));
    chk("to_indata", 64'(inA), 64'(34'h0_1234_5678));
    for (int i = 1; i <= 15; i++) begin
      if (i == 3) begin
        mvA = 1'b1; mdA = 34'h3_0BAD_F00D;
      end else begin
        mvA = 1'b0;
      end
      tick();
      chk("to_not_yet", 64'(toA),   64'(0));
      chk("to_busy",    64'(busyA), 64'(1));
    end
    mvA = 1'b0;
    tick();
    chk("to_set",       64'(toA),   64'(1));
    chk("to_no_write",  64'(wrA),   64'(0));
    tick();
    chk("to_idle",      64'(busyA), 64'(0));
    tick();
    chk("to_next_write",  64'(wrA), 64'(1));
    chk("to_next_indata", 64'(inA), 64'(34'h3_0BAD_F00D));
    wdA = 1'b1;
    tick();
    chk("to_next_release", 64'(busyA), 64'(1));
    wdA = 1'b0;
    tick();
    chk("to_next_idle", 64'(busyA), 64'(0));
    wdA = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("late_wd_no_write", 64'(wrA),   64'(0));
      chk("late_wd_no_busy",  64'(busyA), 64'(0));
    end
    wdA = 1'b0;
    tick();
    chk("to_sticky", 64'(toA), 64'(1));
    ecA = 1'b1;
    tick();
    chk("to_cleared", 64'(toA), 64'(0));
    ecA = 1'b0;

    // 5: reset mid-WAIT with 3 words queued
    for (int i = 0; i < 4; i++) begin
      mvA = 1'b1; mdA = 34'(i + 32);
      tick();
    end
    mvA = 1'b0;
    chk("rst_wait_level", 64'(lvlA),  64'(3));
    chk("rst_wait_busy",  64'(busyA), 64'(1));
    rstB = 1'b0;
    tick();
    chkIdleA("rst_wait");
    rstB = 1'b1;
    tick();
    chk("rst_no_relaunch", 64'(wrA),  64'(0));
    chk("rst_level_stays", 64'(lvlA), 64'(0));

    // 6: randomized traffic against a queue model of the synchronizer
    nAcc = 0; nRx = 0; ovExp = 1'b0; wdWait = 0; wdLen = 0; done = 1'b0;
    for (int c = 0; c < 8000 && !done; c++) begin
      mvD = mvB; mdD = mdB; wdDrv = wdB; pre = acc.size();
      tick();
      if (wrB) begin
        chk("rnd_launch_nonempty", 64'(pre > 0), 64'(1));
        chk("rnd_wd_low_at_launch", 64'(wdDrv), 64'(0));
        if (acc.size() > 0) begin
          expW = acc.pop_front();
          chk("rnd_order", 64'(inB), 64'(expW));
        end
        nRx++;
        wdWait = int'($urandom_range(40, 1));
        wdLen  = int'($urandom_range(3, 1));
      end
      if (mvD) begin
        if (pre < DEPTH) begin
          acc.push_back(mdD);
          nAcc++;
        end else begin
          ovExp = 1'b1;
        end
      end
      chk("rnd_level", 64'(lvlB), 64'(acc.size()));
      chk("rnd_ready", 64'(rdyB), 64'(acc.size() < DEPTH));
      if (wdWait > 0) begin
        wdWait--; wdB = 1'b0;
      end else if (wdLen > 0) begin
        wdB = 1'b1; wdLen--;
      end else begin
        wdB = 1'b0;
      end
      mvB = (c < 3000) && ($urandom_range(5, 0) == 0);
      mdB = {2'($urandom_range(3, 0)), 32'($urandom)};
      if (c >= 3000 && acc.size() == 0 && !busyB && wdWait == 0 && wdLen == 0 && !wdB)
        done = 1'b1;
    end
    chk("rnd_drained",  64'(done),  64'(1));
    chk("rnd_rx_count", 64'(nRx),   64'(nAcc));
    chk("rnd_overflow", 64'(ovB),   64'(ovExp));
    chk("rnd_timeout",  64'(toB),   64'(0));
    chk("rnd_some_traffic", 64'(nAcc > 50), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
